// File: rtl/dmrs_pkg.sv
// Shared types, widths and elaboration-time helpers for the DMRS sequencer.
// The prime/reciprocal table is computed here once and frozen into the ROM.
package dmrs_pkg;

  localparam int unsigned MZC_W        = 10;
  localparam int unsigned REC_W        = 30;
  localparam int unsigned MZC_ZC_MIN   = 36;
  localparam int unsigned MZC_V_MIN    = 72;
  localparam int unsigned DMRS_MAX_PRB = 170;
  localparam int unsigned DMRS_GAP_CYC = 2;
  localparam int unsigned DMRS_MAX_SYM = 4;

  // Short lengths served by the generator's fixed phase tables instead of Zadoff-Chu.
  localparam int unsigned ZC_TBL_LEN_0 = 6;
  localparam int unsigned ZC_TBL_LEN_1 = 12;
  localparam int unsigned ZC_TBL_LEN_2 = 18;
  localparam int unsigned ZC_TBL_LEN_3 = 24;
  localparam int unsigned ZC_TBL_LEN_4 = 30;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_RDY, S_RUN, S_GAP, S_DONE
  } state_t;

  function automatic logic [MZC_W-1:0] mzc_of(input logic [7:0] n);
    return MZC_W'(n) * MZC_W'(6);
  endfunction

  function automatic bit is_prime(input int x);
    bit ok;
    ok = (x >= 2);
    for (int d = 2; ok && (d * d <= x); d++) begin
      if (x % d == 0) ok = 1'b0;
    end
    return ok;
  endfunction

  // {largest prime below 6*n, round(2^34/prime)}; zero outside 6..MAX_PRB.
  function automatic logic [MZC_W+REC_W-1:0] prime_entry(input int n);
    int     p;
    int     k;
    longint rec;
    p   = 0;
    rec = 0;
    if (n >= 6 && n <= int'(DMRS_MAX_PRB)) begin
      k = 6 * n - 1;
      while (p == 0 && k >= 2) begin
        if (is_prime(k)) p = k;
        k--;
      end
      rec = ((longint'(1) << 34) + longint'(p / 2)) / longint'(p);
    end
    return {p[MZC_W-1:0], rec[REC_W-1:0]};
  endfunction

endpackage

// File: rtl/dmrs_prime_rom.sv
// Prime / prime-reciprocal lookup indexed by PRB count.
// Pure combinational; the sequencer registers the result during LOAD.
module dmrs_prime_rom
  import dmrs_pkg::*;
(
  input  logic [7:0]       n_prb_i,
  output logic [MZC_W-1:0] prime_o,
  output logic [REC_W-1:0] rec_o
);

  logic [MZC_W+REC_W-1:0] rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [MZC_W+REC_W-1:0] ENTRY = prime_entry(g);
    assign rom[g] = ENTRY;
  end

  assign {prime_o, rec_o} = rom[n_prb_i];

endmodule

// File: rtl/dmrs_seq_ctrl.sv
// DMRS generator sequencer: loads per-slot settings, gates the generator
// per symbol with idle gaps, and tags valid samples for the RE mapper.
//
// state    | meaning
// IDLE     | waiting for start; illegal config pulses err
// LOAD     | register Mzc/u/v/prime/rec, clear sym_idx
// WAIT_RDY | waiting for dst_ready before the next symbol
// RUN      | gen_enable high, counting Mzc valid samples
// GAP      | GAP_CYC idle cycles so the generator clears its finished flag
// DONE     | one-cycle done pulse
module dmrs_seq_ctrl
  import dmrs_pkg::*;
#(
  parameter int unsigned MAX_PRB = DMRS_MAX_PRB,
  parameter int unsigned GAP_CYC = DMRS_GAP_CYC,
  parameter int unsigned MAX_SYM = DMRS_MAX_SYM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       n_prb,
  input  logic [4:0]       u_in,
  input  logic             v_in,
  input  logic [2:0]       num_sym,
  input  logic             dst_ready,
  input  logic             gen_valid,
  output logic             gen_enable,
  output logic [MZC_W-1:0] gen_mzc,
  output logic [4:0]       gen_u,
  output logic             gen_v,
  output logic [MZC_W-1:0] gen_prime,
  output logic [REC_W-1:0] gen_prime_rec,
  output logic [1:0]       sym_idx,
  output logic             samp_first,
  output logic             samp_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  state_t           state_q;
  logic [7:0]       n_prb_q;
  logic [4:0]       u_q;
  logic             v_q;
  logic [2:0]       num_sym_q;
  logic [MZC_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             gen_enable_q, gen_v_q, busy_q, done_q, err_q;
  logic [MZC_W-1:0] gen_mzc_q, gen_prime_q;
  logic [4:0]       gen_u_q;
  logic [REC_W-1:0] gen_prime_rec_q;
  logic [1:0]       sym_idx_q;

  logic [MZC_W-1:0] mzc_d, prime_d;
  logic [REC_W-1:0] rec_d;
  logic             cfg_legal, run_valid, last_hit, last_sym;

  dmrs_prime_rom u_rom (
    .n_prb_i (n_prb_q),
    .prime_o (prime_d),
    .rec_o   (rec_d)
  );

  assign mzc_d     = mzc_of(n_prb_q);
  assign cfg_legal = (n_prb != 8'd0) && (n_prb <= 8'(MAX_PRB)) &&
                     (num_sym != 3'd0) && (num_sym <= 3'(MAX_SYM));
  assign run_valid = (state_q == S_RUN) && gen_valid;
  assign last_hit  = (cnt_q == gen_mzc_q - MZC_W'(1));
  assign last_sym  = ({1'b0, sym_idx_q} == num_sym_q - 3'd1);

  // Tags must line up with the very gen_valid they qualify, hence combinational.
  assign samp_first = run_valid && (cnt_q == '0);
  assign samp_last  = run_valid && last_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      n_prb_q         <= '0;
      u_q             <= '0;
      v_q             <= 1'b0;
      num_sym_q       <= '0;
      cnt_q           <= '0;
      gap_q           <= '0;
      gen_enable_q    <= 1'b0;
      gen_mzc_q       <= '0;
      gen_u_q         <= '0;
      gen_v_q         <= 1'b0;
      gen_prime_q     <= '0;
      gen_prime_rec_q <= '0;
      sym_idx_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q      <= S_IDLE;
        gen_enable_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (cfg_legal) begin
                n_prb_q   <= n_prb;
                u_q       <= u_in;
                v_q       <= v_in;
                num_sym_q <= num_sym;
                busy_q    <= 1'b1;
                state_q   <= S_LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            gen_mzc_q       <= mzc_d;
            gen_u_q         <= u_q;
            gen_v_q         <= (mzc_d >= MZC_W'(MZC_V_MIN)) ? v_q : 1'b0;
            gen_prime_q     <= (mzc_d >= MZC_W'(MZC_ZC_MIN)) ? prime_d : '0;
            gen_prime_rec_q <= (mzc_d >= MZC_W'(MZC_ZC_MIN)) ? rec_d : '0;
            sym_idx_q       <= '0;
            state_q         <= S_WAIT_RDY;
          end
          S_WAIT_RDY: begin
            if (dst_ready) begin
              gen_enable_q <= 1'b1;
              cnt_q        <= '0;
              state_q      <= S_RUN;
            end
          end
          S_RUN: begin
            if (gen_valid) begin
              if (last_hit) begin
                gen_enable_q <= 1'b0;
                gap_q        <= GAP_W'(GAP_CYC - 1);
                state_q      <= S_GAP;
              end else begin
                cnt_q <= cnt_q + MZC_W'(1);
              end
            end
          end
          S_GAP: begin
            if (gap_q == '0) begin
              if (last_sym) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                sym_idx_q <= sym_idx_q + 2'd1;
                state_q   <= S_WAIT_RDY;
              end
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign gen_enable    = gen_enable_q;
  assign gen_mzc       = gen_mzc_q;
  assign gen_u         = gen_u_q;
  assign gen_v         = gen_v_q;
  assign gen_prime     = gen_prime_q;
  assign gen_prime_rec = gen_prime_rec_q;
  assign sym_idx       = sym_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dmrs_seq_ctrl.sv
// Directed bench for dmrs_seq_ctrl: a linear sequence of slots acting as
// generator and RE mapper, with hand-computed settings and sample tags.
module tb_dmrs_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  n_prb = '0;
  logic [4:0]  u_in = '0;
  logic        v_in = 1'b0;
  logic [2:0]  num_sym = '0;
  logic        dst_ready = 1'b0, gen_valid = 1'b0;
  logic        gen_enable, gen_u_dummy;
  logic [9:0]  gen_mzc, gen_prime;
  logic [4:0]  gen_u;
  logic        gen_v;
  logic [29:0] gen_prime_rec;
  logic [1:0]  sym_idx;
  logic        samp_first, samp_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  assign gen_u_dummy = 1'b0;

  dmrs_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_prb(n_prb), .u_in(u_in), .v_in(v_in), .num_sym(num_sym),
    .dst_ready(dst_ready), .gen_valid(gen_valid),
    .gen_enable(gen_enable), .gen_mzc(gen_mzc), .gen_u(gen_u), .gen_v(gen_v),
    .gen_prime(gen_prime), .gen_prime_rec(gen_prime_rec), .sym_idx(sym_idx),
    .samp_first(samp_first), .samp_last(samp_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in WAIT_RDY with the new settings registered.
  task automatic start_slot(input int n, input int u, input int v, input int ns);
    n_prb = 8'(n); u_in = 5'(u); v_in = 1'(v); num_sym = 3'(ns);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_load", busy, 1);
    step();
    chk("wait_en", gen_enable, 0);
  endtask

  // Called right after the edge that entered RUN; acts as the generator.
  task automatic run_sym(input int mzc, input int sidx, input int bubble_at);
    chk("en_rise", gen_enable, 1);
    chk("sym_idx", sym_idx, sidx);
    for (int i = 0; i < mzc; i++) begin
      if (i == bubble_at) begin
        gen_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
          step();
          chk("en_hold", gen_enable, 1);
        end
      end
      gen_valid = 1'b1;
      #1;
      chk("first", samp_first, (i == 0));
      chk("last", samp_last, (i == mzc - 1));
      step();
    end
    gen_valid = 1'b0;
    chk("en_fall", gen_enable, 0);
  endtask

  task automatic gap_fin(input bit last);
    step();
    chk("gap_en", gen_enable, 0);
    chk("gap_done", done, 0);
    step();
    if (last) begin
      chk("done", done, 1);
      chk("busy_done", busy, 1);
      step();
      chk("done_pulse", done, 0);
      chk("busy_end", busy, 0);
    end else begin
      chk("wait2_en", gen_enable, 0);
      chk("wait2_done", done, 0);
    end
  endtask

  task automatic illegal(input string tag, input int n, input int ns);
    n_prb = 8'(n); num_sym = 3'(ns);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_err"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, gen_enable, 0);
    step();
    chk({tag, "_err_pulse"}, err, 0);
    chk({tag, "_busy2"}, busy, 0);
  endtask

  initial begin
    #3;
    chk("rst_en", gen_enable, 0);
    chk("rst_mzc", gen_mzc, 0);
    chk("rst_prime", gen_prime, 0);
    chk("rst_rec", gen_prime_rec, 0);
    chk("rst_flags", {busy, done, err, gen_v, samp_first, samp_last}, 0);
    chk("rst_misc", {gen_u, sym_idx}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dst_ready = 1'b1;

    // Smallest Zadoff-Chu length: v must be forced to 0.
    start_slot(6, 3, 1, 1);
    chk("t1_mzc", gen_mzc, 36);
    chk("t1_u", gen_u, 3);
    chk("t1_v", gen_v, 0);
    chk("t1_prime", gen_prime, 31);
    chk("t1_rec", gen_prime_rec, 554189329);
    step();
    run_sym(36, 0, -1);
    gap_fin(1'b1);
    chk("t1_cfg_hold", gen_mzc, 36);

    // Mzc=72 is the first length where v passes through; includes a valid bubble.
    start_slot(12, 7, 1, 1);
    chk("t2_mzc", gen_mzc, 72);
    chk("t2_prime", gen_prime, 71);
    chk("t2_rec", gen_prime_rec, 241969989);
    chk("t2_v", gen_v, 1);
    chk("t2_u", gen_u, 7);
    step();
    run_sym(72, 0, 5);
    gap_fin(1'b1);

    start_slot(11, 0, 1, 1);
    chk("t3_mzc", gen_mzc, 66);
    chk("t3_prime", gen_prime, 61);
    chk("t3_rec", gen_prime_rec, 281637200);
    chk("t3_v", gen_v, 0);
    step();
    run_sym(66, 0, -1);
    gap_fin(1'b1);

    // Table-based lengths carry no prime.
    start_slot(5, 1, 1, 1);
    chk("t4_mzc", gen_mzc, 30);
    chk("t4_prime", gen_prime, 0);
    chk("t4_rec", gen_prime_rec, 0);
    step();
    run_sym(30, 0, -1);
    gap_fin(1'b1);

    start_slot(1, 2, 0, 1);
    chk("t5_mzc", gen_mzc, 6);
    chk("t5_prime", gen_prime, 0);
    step();
    run_sym(6, 0, -1);
    gap_fin(1'b1);

    // Three symbols with the mapper stalling before the last one.
    start_slot(2, 4, 0, 3);
    chk("t6_mzc", gen_mzc, 12);
    step();
    run_sym(12, 0, -1);
    gap_fin(1'b0);
    chk("t6_idx1", sym_idx, 1);
    step();
    run_sym(12, 1, -1);
    dst_ready = 1'b0;
    gap_fin(1'b0);
    chk("t6_idx2", sym_idx, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_stall_en", gen_enable, 0);
      chk("t6_stall_busy", busy, 1);
    end
    dst_ready = 1'b1;
    step();
    run_sym(12, 2, -1);
    gap_fin(1'b1);

    // Abort on the 5th sample of the second symbol, then a clean restart.
    start_slot(4, 9, 0, 2);
    chk("t7_mzc", gen_mzc, 24);
    step();
    run_sym(24, 0, -1);
    gap_fin(1'b0);
    step();
    chk("t7_en", gen_enable, 1);
    chk("t7_idx", sym_idx, 1);
    for (int i = 0; i < 4; i++) begin
      gen_valid = 1'b1;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    gen_valid = 1'b0;
    chk("t7_abort_en", gen_enable, 0);
    chk("t7_abort_busy", busy, 0);
    chk("t7_abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t7_no_done", {done, err, gen_enable}, 0);
    end
    start_slot(3, 5, 1, 1);
    chk("t7_re_mzc", gen_mzc, 18);
    chk("t7_re_idx", sym_idx, 0);
    step();
    run_sym(18, 0, -1);
    gap_fin(1'b1);

    // Abort beats a legal start in the same cycle.
    n_prb = 8'd2; num_sym = 3'd1;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t8_busy", busy, 0);
    step();
    chk("t8_busy2", {busy, err, gen_enable}, 0);

    // Illegal configs, with a stray gen_valid that must not be tagged.
    gen_valid = 1'b1;
    #1;
    chk("t9_stray_tag", {samp_first, samp_last}, 0);
    illegal("prb0", 0, 1);
    illegal("prb171", 171, 1);
    illegal("sym5", 170, 5);
    illegal("sym0", 10, 0);
    gen_valid = 1'b0;

    // Largest legal allocation is accepted.
    start_slot(170, 31, 1, 1);
    chk("t10_mzc", gen_mzc, 1020);
    chk("t10_v", gen_v, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Async reset in the middle of a symbol drops enable without a clock.
    start_slot(6, 3, 0, 1);
    step();
    chk("t11_en", gen_enable, 1);
    gen_valid = 1'b1;
    step();
    step();
    gen_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t11_rst_en", gen_enable, 0);
    chk("t11_rst_busy", busy, 0);
    chk("t11_rst_mzc", gen_mzc, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t11_idle", {busy, gen_enable, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
